pc_fetch_sequencer: RTL and testbench

- Owns the program counter and sequences instruction fetch for the KGP-RISC core.
- Issues instruction-memory read requests with a req/ack handshake and computes the next PC through the team's existing add4 incrementer.
- Applies branch/jump redirects, pipeline stalls and halt/resume.
- Sits between the instruction memory port and the decode stage.

---
 rtl/pc_fetch_sequencer_pkg.sv | 32 +++
 rtl/add4.sv | 18 +
 rtl/pc_fetch_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_sequencer_pkg.sv
//============================================================================
// Module   : pc_fetch_sequencer_pkg
// Purpose  : Shared types and constants for the KGP-RISC fetch sequencer:
//            FSM state encoding, PC width and the default reset vector.
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

package pc_fetch_sequencer_pkg;

  // PC/address width; tied to 32 because the add4 incrementer is 32 bits.
  localparam int unsigned PCSEQ_PC_W = 32;

  // First address fetched after reset.
  localparam logic [31:0] PCSEQ_RESET_VECTOR = 32'h0000_0000;

  // Fetch FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT   = 2'd2,
    ST_HALTED = 2'd3
  } pcseq_state_e;

  // True when an address is not word aligned.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb != 2'b00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/add4.sv
//============================================================================
// Module   : add4
// Purpose  : 32-bit constant incrementer, out = inp + 4 (modulo 2^32).
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

module add4 (
  input  logic [31:0] inp,
  output logic [31:0] out
);

  // Carry out of bit 31 is dropped so 32'hFFFF_FFFC wraps to zero.
  assign out = inp + 32'd4;

endmodule

`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
//============================================================================
// Module   : pc_fetch_sequencer
// Purpose  : Owns the program counter and sequences instruction fetch over a
//            req/ack memory port, with redirect, stall and halt/resume.
// Options  : PCSEQ_ALIGN_CHECK_EN - adds misalign_trap; a redirect to a
//            non word-aligned target traps and halts instead of fetching.
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int unsigned      PC_W         = PCSEQ_PC_W,
  parameter logic [PC_W-1:0]  RESET_VECTOR = PCSEQ_RESET_VECTOR
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  output logic            instr_valid,
  output logic [PC_W-1:0] instr_pc,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_target,
  input  logic            halt,
  input  logic            resume,
  output logic            halted,
  output logic [PC_W-1:0] pc_plus4
`ifdef PCSEQ_ALIGN_CHECK_EN
  ,
  output logic            misalign_trap
`endif
);

  pcseq_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            instr_valid_q, instr_valid_d;
  logic [PC_W-1:0] instr_pc_q, instr_pc_d;
  logic            redir_pend_q, redir_pend_d;
  logic [PC_W-1:0] redir_tgt_q, redir_tgt_d;
  logic            halt_pend_q, halt_pend_d;
`ifdef PCSEQ_ALIGN_CHECK_EN
  logic            trap_q, trap_d;
`endif

  // Redirect that takes effect on pc at the coming edge, and the word-discard flag.
  logic            apply_redir;
  logic [PC_W-1:0] apply_tgt;
  logic            discard;

  add4 u_add4 (
    .inp (pc_q),
    .out (pc_plus4)
  );

  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr_pc    = instr_pc_q;
  assign halted      = (state_q == ST_HALTED);
`ifdef PCSEQ_ALIGN_CHECK_EN
  assign misalign_trap = trap_q;
`endif

  // Next-state, pc update and request generation for the fetch FSM.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_valid_d = 1'b0;
    instr_pc_d    = instr_pc_q;
    redir_pend_d  = redir_pend_q;
    redir_tgt_d   = redir_tgt_q;
    halt_pend_d   = halt_pend_q;
    imem_req      = 1'b0;
    apply_redir   = 1'b0;
    apply_tgt     = redirect_target;
    discard       = 1'b0;
`ifdef PCSEQ_ALIGN_CHECK_EN
    trap_d        = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        apply_redir = redirect_valid;
        state_d     = halt ? ST_HALTED : ST_REQ;
      end
      ST_REQ: begin
        // A redirect or halt here suppresses the fetch of the current pc.
        if (redirect_valid) begin
          apply_redir = 1'b1;
          if (halt) begin
            state_d = ST_HALTED;
          end
        end else if (halt) begin
          state_d = ST_HALTED;
        end else if (!stall) begin
          imem_req = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Request is committed: hold it and remember redirect/halt for the ack.
        imem_req = 1'b1;
        if (redirect_valid) begin
          redir_pend_d = 1'b1;
          redir_tgt_d  = redirect_target;
        end
        if (halt) begin
          halt_pend_d = 1'b1;
        end
      end
      ST_HALTED: begin
        apply_redir = redirect_valid;
        if (resume && !halt) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Transfer completes in any cycle where the request is acknowledged.
    if (imem_req && imem_ack) begin
      discard       = redirect_valid || redir_pend_q;
      instr_valid_d = !discard;
      instr_pc_d    = pc_q;
      redir_pend_d  = 1'b0;
      halt_pend_d   = 1'b0;
      state_d       = (halt || halt_pend_q) ? ST_HALTED : ST_REQ;
      if (discard) begin
        apply_redir = 1'b1;
        apply_tgt   = redirect_valid ? redirect_target : redir_tgt_q;
      end else begin
        pc_d = pc_plus4;
      end
    end

    if (apply_redir) begin
      pc_d = apply_tgt;
`ifdef PCSEQ_ALIGN_CHECK_EN
      // Offending target stays in pc for debug; fetching stops.
      if (is_misaligned(apply_tgt[1:0])) begin
        trap_d  = 1'b1;
        state_d = ST_HALTED;
      end
`endif
    end
  end

  // State and datapath registers, asynchronously reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_VECTOR;
      instr_valid_q <= 1'b0;
      instr_pc_q    <= '0;
      redir_pend_q  <= 1'b0;
      redir_tgt_q   <= '0;
      halt_pend_q   <= 1'b0;
`ifdef PCSEQ_ALIGN_CHECK_EN
      trap_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_valid_q <= instr_valid_d;
      instr_pc_q    <= instr_pc_d;
      redir_pend_q  <= redir_pend_d;
      redir_tgt_q   <= redir_tgt_d;
      halt_pend_q   <= halt_pend_d;
`ifdef PCSEQ_ALIGN_CHECK_EN
      trap_q        <= trap_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
//============================================================================
// Module   : tb_pc_fetch_sequencer
// Purpose  : Directed self-checking bench for pc_fetch_sequencer.
//            Define PCSEQ_ALIGN_CHECK_EN to also exercise misalign_trap.
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

module tb_pc_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt;
  logic        resume;
  logic        halted;
  logic [31:0] pc_plus4;
`ifdef PCSEQ_ALIGN_CHECK_EN
  logic        misalign_trap;
`endif

  int checks_total;
  int checks_passed;

  pc_fetch_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .instr_valid     (instr_valid),
    .instr_pc        (instr_pc),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt            (halt),
    .resume          (resume),
    .halted          (halted),
    .pc_plus4        (pc_plus4)
`ifdef PCSEQ_ALIGN_CHECK_EN
    ,
    .misalign_trap   (misalign_trap)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) begin
      checks_passed++;
    end else begin
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Acknowledge the current request after it has waited `waits` WAIT cycles.
  task automatic ack_after(input int waits);
    repeat (waits) tick();
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    #1;
  endtask

  initial begin
    checks_total   = 0;
    checks_passed  = 0;
    rst_n          = 1'b0;
    imem_ack       = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    halt           = 1'b0;
    resume         = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_req",      imem_req, 0);
    check("rst_valid",    instr_valid, 0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_halted",   halted, 0);
    check("rst_addr",     imem_addr, 32'h0);
    check("rst_plus4",    pc_plus4, 32'h4);

    // Release: one IDLE cycle, then request for 0x0
    rst_n = 1'b1;
    #1;
    check("idle_req", imem_req, 0);
    tick();
    check("req0_req",  imem_req, 1);
    check("req0_addr", imem_addr, 32'h0);

    // Sequential fetches 0x0, 0x4 with ack one cycle after req
    ack_after(1);
    check("v0_valid", instr_valid, 1);
    check("v0_pc",    instr_pc, 32'h0);
    check("req4_req", imem_req, 1);
    check("req4_addr", imem_addr, 32'h4);
    ack_after(1);
    check("v4_valid", instr_valid, 1);
    check("v4_pc",    instr_pc, 32'h4);
    check("req8_addr", imem_addr, 32'h8);

    // Stall for 3 cycles in REQ
    stall = 1'b1;
    #1;
    check("stall0_req", imem_req, 0);
    tick();
    check("stall1_req", imem_req, 0);
    check("stall1_valid", instr_valid, 0);
    tick();
    check("stall2_req", imem_req, 0);
    check("stall2_addr", imem_addr, 32'h8);
    stall = 1'b0;
    #1;
    check("unstall_req",  imem_req, 1);
    check("unstall_addr", imem_addr, 32'h8);
    ack_after(1);
    check("v8_valid", instr_valid, 1);
    check("v8_pc",    instr_pc, 32'h8);
    tick();
    check("v8_pulse_end", instr_valid, 0);
    check("wait_c_addr", imem_addr, 32'hC);
    ack_after(0);
    check("vc_valid", instr_valid, 1);
    check("vc_pc",    instr_pc, 32'hC);
    check("req10_addr", imem_addr, 32'h10);

    // Redirect together with ack of 0x10
    tick();
    redirect_valid  = 1'b1;
    redirect_target = 32'h100;
    imem_ack        = 1'b1;
    tick();
    redirect_valid = 1'b0;
    imem_ack       = 1'b0;
    #1;
    check("rd_ack_valid", instr_valid, 0);
    check("rd_ack_req",   imem_req, 1);
    check("rd_ack_addr",  imem_addr, 32'h100);
    ack_after(1);
    check("v100_valid", instr_valid, 1);
    check("v100_pc",    instr_pc, 32'h100);

    // Redirect in REQ: old pc 0x104 is never requested
    redirect_valid  = 1'b1;
    redirect_target = 32'h20;
    #1;
    check("rd_req_noreq", imem_req, 0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("req20_req",  imem_req, 1);
    check("req20_addr", imem_addr, 32'h20);

    // Halt during WAIT for 0x20, ack two cycles later
    tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    #1;
    check("hpend_req",    imem_req, 1);
    check("hpend_halted", halted, 0);
    ack_after(1);
    check("v20_valid",  instr_valid, 1);
    check("v20_pc",     instr_pc, 32'h20);
    check("v20_halted", halted, 1);
    check("v20_req",    imem_req, 0);
    tick();
    check("halt_req",   imem_req, 0);
    check("halt_valid", instr_valid, 0);

    // Resume -> IDLE -> request 0x24
    resume = 1'b1;
    tick();
    resume = 1'b0;
    #1;
    check("resume_halted", halted, 0);
    check("resume_idle_req", imem_req, 0);
    tick();
    check("req24_req",  imem_req, 1);
    check("req24_addr", imem_addr, 32'h24);

    // Wrap: redirect to 0xFFFF_FFFC then fetch
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("top_addr",  imem_addr, 32'hFFFF_FFFC);
    check("top_plus4", pc_plus4, 32'h0);
    ack_after(1);
    check("vtop_pc",   instr_pc, 32'hFFFF_FFFC);
    check("wrap_addr", imem_addr, 32'h0);

    // Two redirects while waiting: last one wins, in-flight word dropped
    tick();
    redirect_valid  = 1'b1;
    redirect_target = 32'h200;
    tick();
    redirect_target = 32'h300;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("rdw_addr_stable", imem_addr, 32'h0);
    ack_after(0);
    check("rdw_valid", instr_valid, 0);
    check("rdw_addr",  imem_addr, 32'h300);

    // Halt in REQ, then halt+resume together: halt wins
    halt = 1'b1;
    #1;
    check("hreq_req", imem_req, 0);
    tick();
    check("hreq_halted", halted, 1);
    resume = 1'b1;
    tick();
    check("hr_both_halted", halted, 1);
    halt = 1'b0;
    tick();
    resume = 1'b0;
    #1;
    check("hr_resume_halted", halted, 0);

    // Reset mid-transaction
    tick();
    tick();
    check("mid_req", imem_req, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req",   imem_req, 0);
    check("mid_rst_addr",  imem_addr, 32'h0);
    check("mid_rst_valid", instr_valid, 0);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("mid_rst_novalid", instr_valid, 0);

`ifdef PCSEQ_ALIGN_CHECK_EN
    // Misaligned redirect traps and halts
    rst_n = 1'b1;
    tick();
    redirect_valid  = 1'b1;
    redirect_target = 32'h102;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("trap_pulse",  misalign_trap, 1);
    check("trap_halted", halted, 1);
    check("trap_req",    imem_req, 0);
    check("trap_pc",     imem_addr, 32'h102);
    tick();
    check("trap_end",    misalign_trap, 0);
    check("trap_noreq",  imem_req, 0);
`endif

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

`default_nettype wire
